data_sram_axi_bridge: RTL
=========================

Name: data_sram_axi_bridge

Overview:
- Responder for the core's data_sram request interface (en/rlen/wen/addr/wdata to rdata), issued by the memory-access stage.
- Converts each request into one single-beat AXI4 read or write transaction.
- Stalls the pipeline until the transaction completes.
- Sits between the MEM stage and the AXI crossbar (uncached data path), one outstanding transaction at a time.

Parameters:
AXI_ID, 4'd1, constant ARID/AWID/WID driven on every transaction
ID_W, 4, width of AXI ID fields

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
data_sram_en  in  1  request valid; held high by core while stalled
data_sram_rlen  in  2  read size: 0=1B, 1=2B, 2=4B
data_sram_wen  in  4  byte write enables; nonzero=write, zero=read
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  write data, lanes already replicated by core
data_sram_rdata  out  32  read data (full 32-bit AXI word), valid in DONE cycle
data_sram_stall  out  1  freeze pipeline
data_bus_err  out  1  one-cycle pulse in DONE when RRESP/BRESP != OKAY
arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1  AXI read address
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI read data
rready  out  1
awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1  AXI write address
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1  AXI write data
wready  in  1
bid/bresp/bvalid  in  ID_W/2/1
bready  out  1

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - All valid/ready outputs 0, data_sram_rdata=0, data_bus_err=0.
  - Latched request registers 0.
- Constant fields: arlen=awlen=0, arburst=awburst=2'b01, wlast=1, ids=AXI_ID.
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE:
  - If data_sram_en, latch addr, wen, wdata and size.
  - Read size = rlen. Write size from wen: 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; anything else -> 2.
  - Go to AW_W if wen!=0, else AR.
- AR:
  - arvalid=1, araddr=latched addr.
  - On arready, drop arvalid and go to R.
- R:
  - rready=1.
  - On rvalid: capture rdata into data_sram_rdata, capture err=(rresp!=0), go to DONE.
- AW_W:
  - awvalid and wvalid raised together in the first AW_W cycle.
  - Each drops independently after its own handshake, tracked by flags aw_done and w_done.
  - Go to B when both handshakes have completed; a same-cycle handshake of both counts.
  - wstrb = latched wen, wdata = latched wdata.
- B:
  - bready=1.
  - On bvalid, capture err=(bresp!=0) and go to DONE.
- DONE:
  - One cycle. stall=0, data_bus_err=latched err. Go to IDLE.
  - data_sram_en in DONE is ignored: it belongs to the request just completed.
- data_sram_stall (combinational) = (state==IDLE && data_sram_en) || state in {AR, R, AW_W, B}.
  - Minimum latency: request at cycle 0, ready=1 always, read completes in DONE at cycle 3. Stall is high for cycles 0-2.
- AXI valid rule: once asserted, a valid stays high and its payload stays stable until the handshake, regardless of data_sram_en changing.
- data_sram_rdata holds its value until the next read completes; writes do not modify it.
- Response ID mismatch is not checked; one transaction is outstanding at a time.
- Reset mid-transaction: all valids drop immediately and the FSM returns to IDLE. No DONE and no error pulse are produced. The interconnect is reset by the same resetn.
- Address is passed through unmodified; no address translation in this block.

Decomposition:
- Shared package (cpu_axi_pkg):
  - AXI constants: BURST_INCR, RESP_OKAY, SIZE_1B/2B/4B.
  - Enum type for the bridge FSM states.
  - Function wen_to_size(logic [3:0]) -> logic [2:0].
- No sub-module needed; single FSM plus request registers.

Test Plan:
- Aligned LW, addr=0x1000_0004, rlen=2, arready/rvalid immediate, rdata=0xDEADBEEF:
  - Transaction: araddr=0x1000_0004, arsize=2.
  - Stall high for 3 cycles; DONE shows rdata=0xDEADBEEF, data_bus_err=0.
- SB, addr=0x1000_0003, wen=1000, wdata=0x5A5A5A5A, awready delayed 3 cycles, wready immediate:
  - wvalid drops after 1 cycle while awvalid is held.
  - awsize=0, wstrb=1000; DONE arrives after bvalid.
- SH, wen=1100, AW and W accepted in the same cycle, bvalid 2 cycles later:
  - awsize=1; B entered next cycle; stall deasserts exactly in the DONE cycle.
- Read with rresp=2'b10 (SLVERR):
  - data_bus_err pulses for exactly one cycle in DONE; rdata still captured.
- resetn asserted low while in R with rvalid not yet given:
  - All valids and rready are 0 immediately; state=IDLE; no err pulse.
  - A new LW after reset completes normally.
- Back-to-back: LW completes, SW issued in the cycle after DONE:
  - data_sram_en during DONE starts nothing.
  - SW starts AW_W from IDLE; the earlier read data stays on data_sram_rdata.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// Shared AXI constants, bridge FSM state type and write-size helper for the
// uncached data-path AXI bridge.
package cpu_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_1B    = 3'd0;
  localparam logic [2:0] SIZE_2B    = 3'd1;
  localparam logic [2:0] SIZE_4B    = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_DONE
  } bridge_state_e;

  // Single-lane strobes are byte stores, aligned half-word pairs are halves,
  // everything else is issued as a full word.
  function automatic logic [2:0] wen_to_size(input logic [3:0] wen);
    logic [2:0] size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_1B;
      4'b0011, 4'b1100:                   size = SIZE_2B;
      default:                            size = SIZE_4B;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Turns each data_sram request from the MEM stage into one single-beat AXI4
// read or write, stalling the pipeline until the response returns.
module data_sram_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            data_sram_en,
  input  logic [1:0]      data_sram_rlen,
  input  logic [3:0]      data_sram_wen,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic [31:0]     data_sram_rdata,
  output logic            data_sram_stall,
  output logic            data_bus_err,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  bridge_state_e r_state;

  logic [31:0] r_addr;
  logic [3:0]  r_wen;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic        w_aw_fin;
  logic        w_w_fin;
  logic        w_stall;
  logic        w_unused_resp;

  // A handshake in the current cycle counts as completed for the AW_W exit test.
  assign w_aw_fin = r_aw_done | (r_awvalid & awready);
  assign w_w_fin  = r_w_done  | (r_wvalid  & wready);

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:                    w_stall = data_sram_en;
      ST_AR, ST_R, ST_AW_W, ST_B: w_stall = 1'b1;
      default:                    w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wen     <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (data_sram_en) begin
            r_addr  <= data_sram_addr;
            r_wen   <= data_sram_wen;
            r_wdata <= data_sram_wdata;
            if (data_sram_wen != '0) begin
              r_size    <= wen_to_size(data_sram_wen);
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_AW_W;
            end else begin
              r_size    <= {1'b0, data_sram_rlen};
              r_arvalid <= 1'b1;
              r_state   <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            r_rready  <= 1'b0;
            r_rdata   <= rdata;
            r_bus_err <= (rresp != RESP_OKAY);
            r_state   <= ST_DONE;
          end
        end
        ST_AW_W: begin
          r_awvalid <= ~w_aw_fin;
          r_wvalid  <= ~w_w_fin;
          r_aw_done <= w_aw_fin;
          r_w_done  <= w_w_fin;
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= ST_B;
          end
        end
        ST_B: begin
          if (bvalid) begin
            r_bready  <= 1'b0;
            r_bus_err <= (bresp != RESP_OKAY);
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Response IDs and RLAST carry no information with a single outstanding beat.
  assign w_unused_resp = ^{rid, rlast, bid};

  assign data_sram_rdata = r_rdata;
  assign data_sram_stall = w_stall;
  assign data_bus_err    = r_bus_err;

  assign arid    = AXI_ID;
  assign araddr  = r_addr;
  assign arlen   = '0;
  assign arsize  = r_size;
  assign arburst = BURST_INCR;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  assign awid    = AXI_ID;
  assign awaddr  = r_addr;
  assign awlen   = '0;
  assign awsize  = r_size;
  assign awburst = BURST_INCR;
  assign awvalid = r_awvalid;

  assign wid     = AXI_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_wen;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

endmodule
